// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with selectable data width, parity, stop bits and zero-gap back-to-back frames
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d, bit_nx;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap, last_stop, last_bit, parity, accept;
  assign wrap      = cnt_q == CNT_W'(CLKS_PER_BIT - 1);
  assign last_stop = stop_q == 1'(STOP_BITS - 1);
  assign last_bit  = bit_q == BIT_W'(DATA_BITS - 1);
  assign parity    = (^data_q) ^ (PARITY_ODD != 0);
  assign bit_nx    = bit_q + 1'b1;
  assign tx_ready  = (state_q == IDLE) || (state_q == STOP && last_stop && wrap);
  assign accept    = tx_valid && tx_ready;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  // Next state, bit timing and the registered line value for the coming cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = (state_q == IDLE) ? '0 : (wrap ? '0 : cnt_q + 1'b1);
    bit_d    = bit_q;
    stop_d   = stop_q;
    data_d   = data_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: serial_d = 1'b1;
      START: if (wrap) begin
        state_d  = DATA;
        bit_d    = '0;
        serial_d = data_q[0];
      end
      DATA: if (wrap) begin
        if (last_bit) begin
          state_d  = (PARITY_EN != 0) ? PARITY : STOP;
          serial_d = (PARITY_EN != 0) ? parity : 1'b1;
          stop_d   = 1'b0;
        end else begin
          bit_d    = bit_nx;
          serial_d = data_q[bit_nx];
        end
      end
      PARITY: if (wrap) begin
        state_d  = STOP;
        stop_d   = 1'b0;
        serial_d = 1'b1;
      end
      STOP: if (wrap) begin
        if (last_stop) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          serial_d = 1'b1;
        end else begin
          stop_d = stop_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        serial_d = 1'b1;
      end
    endcase
    // An accepted word starts its start bit on the accepting edge, even straight out of a stop bit
    if (accept) begin
      state_d  = START;
      cnt_d    = '0;
      bit_d    = '0;
      stop_d   = 1'b0;
      data_d   = tx_data;
      serial_d = 1'b0;
    end
    busy_d = state_d != IDLE;
  end
  // State and output registers; reset aborts any frame silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      data_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
endmodule
